pwm_output_scheduler: RTL and testbench

//  Drives the 16 user outputs from the SPI-written config registers (output enables, PWM enables, duty).

---
 rtl/pwm_output_scheduler.sv | 122 ++++++++++++
 tb/tb_pwm_output_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_output_scheduler.sv
// Shared 8-bit PWM timebase driving 16 output pins; staged config commits only at a period boundary.
//  state | meaning
//  IDLE  | no staged config waiting; active regs drive the pins
//  ARMED | staging holds a new config, committed at the next clean boundary
module pwm_output_scheduler #(
    parameter int PRESCALE = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    input  logic       cfg_valid,
    output logic       cfg_pending,
    output logic       cfg_applied,
    output logic       period_start,
    output logic [7:0] out_lo,
    output logic [7:0] out_hi
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    state_t      state;
    logic [PW-1:0] presc;
    logic [7:0]  pwm_cnt;
    logic        tick;
    logic        boundary;

    logic [15:0] stg_out;
    logic [15:0] stg_pwm;
    logic [7:0]  stg_duty;
    logic [15:0] act_out;
    logic [15:0] act_pwm;
    logic [7:0]  act_duty;

    logic        pwm_lvl;
    logic [15:0] pin_nxt;

    assign tick        = (presc == PRESC_MAX);
    assign boundary    = tick && (pwm_cnt == 8'hFF);
    assign cfg_pending = (state == ARMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            pwm_cnt      <= 8'h00;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + PW'(1);
            period_start <= boundary;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_out  <= 16'h0000;
            stg_pwm  <= 16'h0000;
            stg_duty <= 8'h00;
        end else if (cfg_valid) begin
            stg_out  <= {en_reg_out_15_8, en_reg_out_7_0};
            stg_pwm  <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
            stg_duty <= pwm_duty_cycle;
        end
    end

    // A cfg_valid landing on the boundary cycle defers the commit a full period so staging is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cfg_applied <= 1'b0;
            act_out     <= 16'h0000;
            act_pwm     <= 16'h0000;
            act_duty    <= 8'h00;
        end else begin
            cfg_applied <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (boundary && !cfg_valid) begin
                        act_out     <= stg_out;
                        act_pwm     <= stg_pwm;
                        act_duty    <= stg_duty;
                        cfg_applied <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pwm_lvl = (act_duty == 8'hFF) || (pwm_cnt < act_duty);
        pin_nxt = act_out & ~(act_pwm & {16{~pwm_lvl}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo <= 8'h00;
            out_hi <= 8'h00;
        end else begin
            out_lo <= pin_nxt[7:0];
            out_hi <= pin_nxt[15:8];
        end
    end

endmodule

// File: tb/tb_pwm_output_scheduler.sv
// Scoreboard bench for pwm_output_scheduler at PRESCALE=4 (1024-clk period); expectations are
// hand-computed cycle windows counted in clk edges since reset release.
module tb_pwm_output_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       cfg_valid;
    logic       cfg_pending;
    logic       cfg_applied;
    logic       period_start;
    logic [7:0] out_lo;
    logic [7:0] out_hi;

    pwm_output_scheduler #(.PRESCALE(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .cfg_valid       (cfg_valid),
        .cfg_pending     (cfg_pending),
        .cfg_applied     (cfg_applied),
        .period_start    (period_start),
        .out_lo          (out_lo),
        .out_hi          (out_hi)
    );

    typedef struct {
        int          lo;
        int          hi;
        logic [15:0] pins;
        logic        pend;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   app_q[$];
    int   cyc;
    int   vectors;
    int   miscompares;
    int   ps_count;
    logic cur_bad;
    int   bad_cyc;
    logic [15:0] bad_pins;
    logic bad_pend;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: window checks on pins/pending, plus event checks on cfg_applied and period_start.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && cyc >= exp_q[0].lo) begin
            if ({out_hi, out_lo} !== exp_q[0].pins || cfg_pending !== exp_q[0].pend) begin
                if (!cur_bad) begin
                    bad_cyc  = cyc;
                    bad_pins = {out_hi, out_lo};
                    bad_pend = cfg_pending;
                end
                cur_bad = 1'b1;
            end
            if (cyc >= exp_q[0].hi) begin
                vectors++;
                if (cur_bad) begin
                    miscompares++;
                    $display("FAIL %s: cyc %0d pins=%h pending=%b, required pins=%h pending=%b over cyc %0d..%0d",
                             exp_q[0].name, bad_cyc, bad_pins, bad_pend, exp_q[0].pins, exp_q[0].pend,
                             exp_q[0].lo, exp_q[0].hi);
                end
                void'(exp_q.pop_front());
                cur_bad = 1'b0;
            end
        end
        if (cfg_applied === 1'b1) begin
            vectors++;
            if (app_q.size() == 0) begin
                miscompares++;
                $display("FAIL applied_unexpected: pulse at cyc %0d, required none", cyc);
            end else begin
                int e;
                e = app_q.pop_front();
                if (e != cyc) begin
                    miscompares++;
                    $display("FAIL applied_time: pulse at cyc %0d, required cyc %0d", cyc, e);
                end
            end
        end
        if (period_start === 1'b1) begin
            vectors++;
            ps_count++;
            if (cyc % 1024 != 0 || cyc == 0) begin
                miscompares++;
                $display("FAIL period_start: pulse at cyc %0d, required a nonzero multiple of 1024", cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic expect_win(input int lo, input int hi, input logic [15:0] pins, input logic pend,
                              input string name);
        exp_t e;
        e.lo = lo; e.hi = hi; e.pins = pins; e.pend = pend; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        pwm_duty_cycle  = d;
    endtask

    task automatic pulse(input int n, input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        wait_cyc(n);
        set_cfg(eo, ep, d);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; ps_count = 0; cur_bad = 1'b0;
        bad_cyc = 0; bad_pins = 16'h0; bad_pend = 1'b0;
        cfg_valid = 1'b0;
        set_cfg(16'h0000, 16'h0000, 8'h00);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        expect_win(0, 0, 16'h0000, 1'b0, "reset_state");
        expect_win(1, 2100, 16'h0000, 1'b0, "no_cfg_valid");
        expect_win(2101, 3071, 16'h0000, 1'b1, "all_on_pending");
        expect_win(3072, 3072, 16'h0000, 1'b0, "all_on_commit");
        expect_win(3073, 4100, 16'hFFFF, 1'b0, "all_on_steady");
        expect_win(4101, 5119, 16'hFFFF, 1'b1, "d80_pending");
        expect_win(5120, 5120, 16'hFFFF, 1'b0, "d80_commit");
        expect_win(5121, 5632, 16'h0001, 1'b0, "d80_high1");
        expect_win(5633, 6144, 16'h0000, 1'b0, "d80_low1");
        expect_win(6145, 6656, 16'h0001, 1'b0, "d80_high2");
        expect_win(6657, 6700, 16'h0000, 1'b0, "d80_low2");
        expect_win(6701, 7167, 16'h0000, 1'b1, "d00_pending");
        expect_win(7168, 7168, 16'h0000, 1'b0, "d00_commit");
        expect_win(7169, 8000, 16'h0000, 1'b0, "d00_const_low");
        expect_win(8001, 8191, 16'h0000, 1'b1, "dff_pending");
        expect_win(8192, 8192, 16'h0000, 1'b0, "dff_commit");
        expect_win(8193, 11265, 16'h0001, 1'b0, "dff_const_high");
        expect_win(11301, 12287, 16'h0001, 1'b1, "d40_pending");
        expect_win(12288, 12288, 16'h0001, 1'b0, "d40_commit");
        expect_win(12289, 12544, 16'h0001, 1'b0, "d40_high");
        expect_win(12545, 12800, 16'h0000, 1'b0, "d40_low");
        expect_win(12801, 13311, 16'h0000, 1'b1, "d40_kept_while_c0_staged");
        expect_win(13312, 13312, 16'h0000, 1'b0, "dc0_commit");
        expect_win(13313, 13800, 16'h0001, 1'b0, "dc0_high_a");
        expect_win(13801, 14080, 16'h0001, 1'b1, "dc0_high_b");
        expect_win(14081, 14336, 16'h0000, 1'b1, "dc0_low_collide");
        expect_win(14337, 15104, 16'h0001, 1'b1, "deferred_high");
        expect_win(15105, 15359, 16'h0000, 1'b1, "deferred_low");
        expect_win(15360, 15360, 16'h0000, 1'b0, "d60_commit");
        expect_win(15361, 15744, 16'h0001, 1'b0, "d60_high");
        expect_win(15745, 16384, 16'h0000, 1'b0, "d60_low");
        expect_win(16385, 16400, 16'h0001, 1'b0, "pre_reset_high");
        expect_win(16401, 16500, 16'h0001, 1'b1, "pre_reset_pending");
        app_q = '{3072, 5120, 7168, 8192, 12288, 13312, 15360};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        wait_cyc(50);
        set_cfg(16'hFFFF, 16'h0000, 8'h80);
        pulse(2100, 16'hFFFF, 16'h0000, 8'h80);
        pulse(4100, 16'h0001, 16'h0001, 8'h80);
        pulse(6700, 16'h0001, 16'h0001, 8'h00);
        pulse(8000, 16'h0001, 16'h0001, 8'hFF);
        pulse(11300, 16'h0001, 16'h0001, 8'h40);
        pulse(12800, 16'h0001, 16'h0001, 8'hC0);
        pulse(13800, 16'h0001, 16'h0001, 8'h20);
        pulse(14335, 16'h0001, 16'h0001, 8'h60);
        pulse(16400, 16'h0001, 16'h0001, 8'h60);

        wait_cyc(16500);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_hi, out_lo} !== 16'h0000 || cfg_pending !== 1'b0 || cfg_applied !== 1'b0 ||
            period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: pins=%h pending=%b applied=%b pstart=%b, required all 0",
                     {out_hi, out_lo}, cfg_pending, cfg_applied, period_start);
        end
        if (exp_q.size() != 0 || app_q.size() != 0) begin
            miscompares++;
            $display("FAIL phase1_drain: %0d windows, %0d applied left, required 0 and 0",
                     exp_q.size(), app_q.size());
        end
        exp_q.delete();
        app_q.delete();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_win(1, 2100, 16'h0000, 1'b0, "post_reset_silent");
        expect_win(2101, 3071, 16'h0000, 1'b1, "post_reset_pending");
        expect_win(3072, 3072, 16'h0000, 1'b0, "post_reset_commit");
        expect_win(3073, 3200, 16'h8001, 1'b0, "post_reset_steady");
        app_q.push_back(3072);

        pulse(2100, 16'h8001, 16'h0000, 8'h60);
        wait_cyc(3210);

        vectors++;
        if (exp_q.size() != 0 || app_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d windows, %0d applied left, required 0 and 0",
                     exp_q.size(), app_q.size());
        end
        vectors++;
        if (ps_count != 19) begin
            miscompares++;
            $display("FAIL period_count: saw %0d period_start pulses, required 19", ps_count);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
